// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues word reads over a req/ack handshake and presents
// each returned word to decode, with stall, redirect and an optional delivery limit.
module fetch_sequencer #(
  parameter logic [0:31] START_PC  = 32'h8002_0000,
  parameter int unsigned PC_STEP   = 4,
  parameter int unsigned MAX_INSNS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [0:31] redirect_pc,
  input  logic [0:31] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [0:31] mem_addr,
  output logic [0:31] insn,
  output logic [0:31] pc,
  output logic        valid_insn,
  output logic [0:31] insn_count,
  output logic        halted
);

  typedef enum logic [1:0] {StIdle, StReq, StDeliver, StHalt} state_e;

  state_e      r_state, w_state;
  logic [0:31] r_fetch_pc, w_fetch_pc;
  logic        r_redirect_pending, w_redirect_pending;
  logic        r_mem_req, w_mem_req;
  logic [0:31] r_mem_addr, w_mem_addr;
  logic [0:31] r_insn, w_insn;
  logic [0:31] r_pc, w_pc;
  logic        r_valid, w_valid;
  logic [0:31] r_count, w_count;
  logic        r_halted, w_halted;

  logic [0:31] w_target;
  logic [0:31] w_count_inc;
  logic [0:31] w_seq_pc;

  assign w_target    = redirect ? redirect_pc : r_fetch_pc;
  assign w_count_inc = (r_count == 32'hFFFF_FFFF) ? r_count : r_count + 32'd1;
  assign w_seq_pc    = redirect ? redirect_pc : r_pc + PC_STEP;

  always_comb begin
    w_state            = r_state;
    w_fetch_pc         = r_fetch_pc;
    w_redirect_pending = r_redirect_pending;
    w_mem_req          = r_mem_req;
    w_mem_addr         = r_mem_addr;
    w_insn             = r_insn;
    w_pc               = r_pc;
    w_valid            = r_valid;
    w_count            = r_count;
    w_halted           = r_halted;

    unique case (r_state)
      StIdle: begin
        w_fetch_pc = w_target;
        if (start) begin
          w_state    = StReq;
          w_mem_req  = 1'b1;
          w_mem_addr = w_target;
        end
      end

      StReq: begin
        if (!r_mem_req) begin
          // One-cycle gap after a discarded response; reissue at the latest target.
          w_fetch_pc = w_target;
          w_mem_req  = 1'b1;
          w_mem_addr = w_target;
        end else if (mem_ack) begin
          w_mem_req = 1'b0;
          if (r_redirect_pending || redirect) begin
            w_fetch_pc         = w_target;
            w_redirect_pending = 1'b0;
          end else begin
            w_insn  = mem_rdata;
            w_pc    = r_fetch_pc;
            w_valid = 1'b1;
            w_state = StDeliver;
          end
        end else if (redirect) begin
          // mem_addr keeps the in-flight address until the response arrives.
          w_fetch_pc         = redirect_pc;
          w_redirect_pending = 1'b1;
        end
      end

      StDeliver: begin
        if (!stall || redirect) begin
          w_count    = w_count_inc;
          w_valid    = 1'b0;
          w_fetch_pc = w_seq_pc;
          if ((MAX_INSNS != 0) && (w_count_inc == MAX_INSNS)) begin
            w_state  = StHalt;
            w_halted = 1'b1;
          end else begin
            w_state    = StReq;
            w_mem_req  = 1'b1;
            w_mem_addr = w_seq_pc;
          end
        end
      end

      StHalt: begin
        w_mem_req = 1'b0;
        w_valid   = 1'b0;
        w_halted  = 1'b1;
      end

      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= StIdle;
      r_fetch_pc         <= START_PC;
      r_redirect_pending <= 1'b0;
      r_mem_req          <= 1'b0;
      r_mem_addr         <= START_PC;
      r_insn             <= '0;
      r_pc               <= START_PC;
      r_valid            <= 1'b0;
      r_count            <= '0;
      r_halted           <= 1'b0;
    end else begin
      r_state            <= w_state;
      r_fetch_pc         <= w_fetch_pc;
      r_redirect_pending <= w_redirect_pending;
      r_mem_req          <= w_mem_req;
      r_mem_addr         <= w_mem_addr;
      r_insn             <= w_insn;
      r_pc               <= w_pc;
      r_valid            <= w_valid;
      r_count            <= w_count;
      r_halted           <= w_halted;
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign insn       = r_insn;
  assign pc         = r_pc;
  assign valid_insn = r_valid;
  assign insn_count = r_count;
  assign halted     = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: an unbounded instance and a MAX_INSNS=2 instance
// share the same stimulus; outputs are sampled 1ns after each rising edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [0:31] redirect_pc = '0;
  logic [0:31] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  logic        mem_req, valid_insn, halted;
  logic [0:31] mem_addr, insn, pc, insn_count;
  logic        h_mem_req, h_valid_insn, h_halted;
  logic [0:31] h_mem_addr, h_insn, h_pc, h_insn_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.MAX_INSNS(0)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .insn(insn), .pc(pc),
    .valid_insn(valid_insn), .insn_count(insn_count), .halted(halted)
  );

  fetch_sequencer #(.MAX_INSNS(2)) dut_h (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(h_mem_req), .mem_addr(h_mem_addr), .insn(h_insn), .pc(h_pc),
    .valid_insn(h_valid_insn), .insn_count(h_insn_count), .halted(h_halted)
  );

  task automatic check(input string tag, input logic [0:31] obs, input logic [0:31] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " req"}, {31'd0, mem_req}, 32'd0);
    check({tag, " addr"}, mem_addr, 32'h8002_0000);
    check({tag, " insn"}, insn, 32'd0);
    check({tag, " pc"}, pc, 32'h8002_0000);
    check({tag, " valid"}, {31'd0, valid_insn}, 32'd0);
    check({tag, " count"}, insn_count, 32'd0);
    check({tag, " halted"}, {31'd0, halted}, 32'd0);
    check({tag, " h_halted"}, {31'd0, h_halted}, 32'd0);
    check({tag, " h_req"}, {31'd0, h_mem_req}, 32'd0);
  endtask

  // Single-cycle ack carrying `word`, then release ack.
  task automatic ack_word(input logic [0:31] word);
    mem_ack   = 1'b1;
    mem_rdata = word;
    tick();
    mem_ack   = 1'b0;
  endtask

  logic [0:31] seq_words [3];
  logic [0:31] seq_pcs [3];

  initial begin
    seq_words[0] = 32'h0000_0000; seq_words[1] = 32'h2402_0005; seq_words[2] = 32'h0043_0820;
    seq_pcs[0]   = 32'h8002_0000; seq_pcs[1]   = 32'h8002_0004; seq_pcs[2]   = 32'h8002_0008;

    #12;
    check_reset_state("reset");
    rst = 1'b0;
    tick();
    check("idle req", {31'd0, mem_req}, 32'd0);

    // Sequential fetch, zero wait.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("seq%0d req", i), {31'd0, mem_req}, 32'd1);
      check($sformatf("seq%0d addr", i), mem_addr, seq_pcs[i]);
      check($sformatf("seq%0d valid_pre", i), {31'd0, valid_insn}, 32'd0);
      ack_word(seq_words[i]);
      check($sformatf("seq%0d valid", i), {31'd0, valid_insn}, 32'd1);
      check($sformatf("seq%0d req_low", i), {31'd0, mem_req}, 32'd0);
      check($sformatf("seq%0d insn", i), insn, seq_words[i]);
      check($sformatf("seq%0d pc", i), pc, seq_pcs[i]);
      tick();
      check($sformatf("seq%0d bubble", i), {31'd0, valid_insn}, 32'd0);
      check($sformatf("seq%0d count", i), insn_count, i + 1);
      if (i == 0) check("h halted early", {31'd0, h_halted}, 32'd0);
      if (i == 1) begin
        check("h halted", {31'd0, h_halted}, 32'd1);
        check("h req off", {31'd0, h_mem_req}, 32'd0);
        check("h count", h_insn_count, 32'd2);
      end
    end

    // Variable latency: request held 4 cycles, start pulse ignored everywhere.
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'b0;
      check($sformatf("lat%0d req", i), {31'd0, mem_req}, 32'd1);
      check($sformatf("lat%0d addr", i), mem_addr, 32'h8002_000C);
      check($sformatf("lat%0d valid", i), {31'd0, valid_insn}, 32'd0);
      check($sformatf("lat%0d h_req", i), {31'd0, h_mem_req}, 32'd0);
    end
    stall = 1'b1;
    ack_word(32'h8C43_0010);
    check("lat insn", insn, 32'h8C43_0010);
    check("lat pc", pc, 32'h8002_000C);

    // Stall held 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d valid", i), {31'd0, valid_insn}, 32'd1);
      check($sformatf("stall%0d insn", i), insn, 32'h8C43_0010);
      check($sformatf("stall%0d pc", i), pc, 32'h8002_000C);
      check($sformatf("stall%0d count", i), insn_count, 32'd3);
      check($sformatf("stall%0d req", i), {31'd0, mem_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check("release count", insn_count, 32'd4);
    check("release valid", {31'd0, valid_insn}, 32'd0);
    check("release addr", mem_addr, 32'h8002_0010);

    // Redirect one cycle into an outstanding request; ack two cycles later.
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h8002_0100;
    tick();
    redirect = 1'b0;
    check("rdir addr held", mem_addr, 32'h8002_0010);
    check("rdir req held", {31'd0, mem_req}, 32'd1);
    tick();
    ack_word(32'hDEAD_BEEF);
    check("rdir discard valid", {31'd0, valid_insn}, 32'd0);
    check("rdir gap req", {31'd0, mem_req}, 32'd0);
    tick();
    check("rdir reissue req", {31'd0, mem_req}, 32'd1);
    check("rdir reissue addr", mem_addr, 32'h8002_0100);
    ack_word(32'h1111_1111);
    check("rdir valid", {31'd0, valid_insn}, 32'd1);
    check("rdir pc", pc, 32'h8002_0100);
    check("rdir insn", insn, 32'h1111_1111);
    check("rdir count", insn_count, 32'd4);

    // Redirect and stall together: redirect wins, instruction consumed.
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h8003_0000;
    tick();
    stall    = 1'b0;
    redirect = 1'b0;
    check("rvs count", insn_count, 32'd5);
    check("rvs valid", {31'd0, valid_insn}, 32'd0);
    check("rvs addr", mem_addr, 32'h8003_0000);
    ack_word(32'h2222_2222);
    check("rvs pc", pc, 32'h8003_0000);
    tick();
    check("rvs next addr", mem_addr, 32'h8003_0004);
    check("h still halted", {31'd0, h_halted}, 32'd1);
    check("h count frozen", h_insn_count, 32'd2);
    check("h valid off", {31'd0, h_valid_insn}, 32'd0);

    // Asynchronous reset mid-request; a late ack afterwards is ignored.
    check("pre-rst req", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async rst");
    #3;
    rst     = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    check("late ack req", {31'd0, mem_req}, 32'd0);
    check("late ack valid", {31'd0, valid_insn}, 32'd0);
    check("late ack insn", insn, 32'd0);

    // Start with simultaneous redirect near the top of memory; pc wraps to 0.
    start       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    start    = 1'b0;
    redirect = 1'b0;
    check("wrap addr", mem_addr, 32'hFFFF_FFFC);
    ack_word(32'h3333_3333);
    check("wrap pc", pc, 32'hFFFF_FFFC);
    tick();
    check("wrap next addr", mem_addr, 32'h0000_0000);
    check("wrap count", insn_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
